crossbar_slotted: RTL and testbench

Registered, slot-synchronous N×N crossbar that sits between the ingress VOQs and the egress ports. Schedules arrive from the scheduler through a valid/ready handshake and wait in a one-deep pending register. They take effect only on a slot boundary, so a configuration never changes mid-packet. Output-port conflicts are resolved in hardware (lowest input wins) and flagged, and outputs are registered with one-cycle latency.

---
 rtl/crossbar_pkg.sv | 16 +
 rtl/crossbar_conflict_resolve.sv | 31 +++
 rtl/crossbar_slotted.sv | 123 ++++++++++++
 tb/tb_crossbar_slotted.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared helpers for the slot-synchronous crossbar: select-width derivation and default sizing.
package crossbar_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_PORT_CNT    = 4;
    localparam int DEF_SLOT_CYCLES = 16;

    // Bits needed to index 'n' items; never less than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        while ((2 ** w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/crossbar_conflict_resolve.sv
// Combinational egress-conflict resolver, zero latency: a lower ingress keeps a contested egress.
// No backpressure; purely a function of the offered sel/en.
module crossbar_conflict_resolve #(
    parameter int PORT_CNT = 4,
    parameter int SEL_W    = 2
) (
    input  logic [PORT_CNT*SEL_W-1:0] i_sel,
    input  logic [PORT_CNT-1:0]       i_en,
    output logic [PORT_CNT-1:0]       o_en,
    output logic                      o_conflict
);

    logic [PORT_CNT-1:0] w_en;

    // Compare against the offered enables, so a loser never shields a later ingress.
    always_comb begin
        w_en = i_en;
        for (int i = 1; i < PORT_CNT; i++) begin
            for (int j = 0; j < i; j++) begin
                if (i_en[i] && i_en[j] &&
                    (i_sel[i*SEL_W +: SEL_W] == i_sel[j*SEL_W +: SEL_W])) begin
                    w_en[i] = 1'b0;
                end
            end
        end
    end

    assign o_en       = w_en;
    assign o_conflict = |(i_en ^ w_en);

endmodule

// File: rtl/crossbar_slotted.sv
// Registered N x N crossbar; schedules switch only on slot boundaries, data latency 1 cycle.
// One-deep pending schedule: sched_ready drops after accept until that schedule is promoted.
module crossbar_slotted
    import crossbar_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int PORT_CNT    = DEF_PORT_CNT,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
    parameter int SEL_W       = sel_width(PORT_CNT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [SEL_W*PORT_CNT-1:0]      sched_sel,
    input  logic [PORT_CNT-1:0]            sched_en,
    input  logic                           sched_valid,
    output logic                           sched_ready,
    output logic                           sched_err,
    output logic                           slot_start,
    input  logic [PORT_CNT-1:0]            crossbar_in_en,
    input  logic [DATA_WIDTH*PORT_CNT-1:0] crossbar_in,
    output logic [PORT_CNT-1:0]            crossbar_out_en,
    output logic [DATA_WIDTH*PORT_CNT-1:0] crossbar_out
);

    localparam int             CNT_W    = sel_width(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

    typedef struct packed {
        logic [PORT_CNT-1:0][SEL_W-1:0] sel;
        logic [PORT_CNT-1:0]            en;
    } sched_t;

    logic [CNT_W-1:0]              r_cnt;
    sched_t                        r_pend;
    logic                          r_pend_vld;
    sched_t                        r_act;
    logic                          r_act_vld;
    logic                          r_err;
    logic [PORT_CNT-1:0]           r_out_en;
    logic [DATA_WIDTH*PORT_CNT-1:0] r_out;

    logic                          w_wrap;
    logic                          w_accept;
    logic [PORT_CNT-1:0]           w_res_en;
    logic                          w_conflict;
    sched_t                        w_res;
    logic [PORT_CNT-1:0]           w_out_en;
    logic [DATA_WIDTH*PORT_CNT-1:0] w_out;

    crossbar_conflict_resolve #(
        .PORT_CNT (PORT_CNT),
        .SEL_W    (SEL_W)
    ) u_resolve (
        .i_sel      (sched_sel),
        .i_en       (sched_en),
        .o_en       (w_res_en),
        .o_conflict (w_conflict)
    );

    assign w_wrap     = (r_cnt == CNT_LAST);
    assign w_accept   = sched_valid && !r_pend_vld;
    assign w_res.sel  = sched_sel;
    assign w_res.en   = w_res_en;

    // Accept needs an empty pending slot and promotion needs a full one, so the
    // two never collide; an accept on the wrap edge therefore waits a full slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_act      <= '0;
            r_act_vld  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_err <= w_accept && w_conflict;
            if (w_wrap && r_pend_vld) begin
                r_act      <= r_pend;
                r_act_vld  <= 1'b1;
                r_pend_vld <= 1'b0;
            end
            if (w_accept) begin
                r_pend     <= w_res;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // The active schedule is conflict-free, so OR-ing candidates yields the single match.
    always_comb begin
        w_out_en = '0;
        w_out    = '0;
        for (int o = 0; o < PORT_CNT; o++) begin
            for (int i = 0; i < PORT_CNT; i++) begin
                if (r_act_vld && r_act.en[i] && crossbar_in_en[i] &&
                    (r_act.sel[i] == SEL_W'(o))) begin
                    w_out_en[o] = 1'b1;
                    w_out[o*DATA_WIDTH +: DATA_WIDTH] =
                        w_out[o*DATA_WIDTH +: DATA_WIDTH] |
                        crossbar_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_en <= '0;
            r_out    <= '0;
        end else begin
            r_out_en <= w_out_en;
            r_out    <= w_out;
        end
    end

    assign sched_ready     = !r_pend_vld;
    assign sched_err       = r_err;
    assign slot_start      = (r_cnt == '0) && r_act_vld;
    assign crossbar_out_en = r_out_en;
    assign crossbar_out    = r_out;

endmodule

// File: tb/tb_crossbar_slotted.sv
// Directed bench for crossbar_slotted with 4 ports, 32-bit words and 4-cycle slots.
module tb_crossbar_slotted;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        sched_sel;
    logic [3:0]        sched_en;
    logic              sched_valid;
    logic              sched_ready;
    logic              sched_err;
    logic              slot_start;
    logic [3:0]        in_en;
    logic [3:0][31:0]  xin;
    logic [3:0]        out_en;
    logic [3:0][31:0]  xout;

    int n_total = 0;
    int n_pass  = 0;
    int tb_cnt  = 0;

    always #5 clk = ~clk;

    crossbar_slotted #(
        .DATA_WIDTH  (32),
        .PORT_CNT    (4),
        .SLOT_CYCLES (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sched_sel       (sched_sel),
        .sched_en        (sched_en),
        .sched_valid     (sched_valid),
        .sched_ready     (sched_ready),
        .sched_err       (sched_err),
        .slot_start      (slot_start),
        .crossbar_in_en  (in_en),
        .crossbar_in     (xin),
        .crossbar_out_en (out_en),
        .crossbar_out    (xout)
    );

    // Slot position reference: restarts at 0 after reset, wraps after 3.
    always @(posedge clk) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    end

    typedef struct {
        logic [3:0]       in_en;
        logic [3:0][31:0] din;
        logic [3:0]       exp_en;
        logic [3:0][31:0] exp_dat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic wait_cnt(input int c);
        int k;
        k = 0;
        while (tb_cnt != c && k < 16) begin
            @(negedge clk);
            k++;
        end
        if (tb_cnt != c) begin
            n_total++;
            $display("FAIL sync: slot position %0d never reached", c);
        end
    endtask

    function automatic logic [3:0][31:0] rev(input logic [3:0][31:0] d);
        return {d[0], d[1], d[2], d[3]};
    endfunction

    function automatic logic [3:0][31:0] mkdat(input logic [31:0] base);
        logic [3:0][31:0] d;
        for (int i = 0; i < 4; i++) d[i] = base + 32'(i);
        return d;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][31:0] d;

        vecs[0] = '{4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'hF, {32'hA0, 32'hA1, 32'hA2, 32'hA3}};
        vecs[1] = '{4'b0101, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 4'b1010, {32'hB0, 32'h0, 32'hB2, 32'h0}};
        vecs[2] = '{4'b0000, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 4'b0000, {32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[3] = '{4'b1000, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 4'b0001, {32'h0, 32'h0, 32'h0, 32'hD3}};
        vecs[4] = '{4'hF, {32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF, 32'h0}, 4'hF,
                    {32'h0, 32'hFFFFFFFF, 32'h12345678, 32'hDEADBEEF}};

        reset       = 1'b1;
        sched_valid = 1'b0;
        sched_sel   = 8'h00;
        sched_en    = 4'h0;
        in_en       = 4'hF;
        xin         = {32'h33, 32'h22, 32'h11, 32'h00};
        repeat (3) @(negedge clk);
        chk("rst_out_en", out_en, 0);
        chk("rst_out", xout, 0);
        chk("rst_ready", sched_ready, 1);
        chk("rst_err", sched_err, 0);
        chk("rst_slot_start", slot_start, 0);
        reset = 1'b0;

        // Idle: no schedule yet, traffic must not pass.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("idle_out_en", out_en, 0);
            chk("idle_out", xout, 0);
            chk("idle_slot_start", slot_start, 0);
            chk("idle_ready", sched_ready, 1);
        end

        // Reversal schedule accepted mid-slot, promoted at the next wrap.
        wait_cnt(1);
        sched_sel   = 8'h1B;
        sched_en    = 4'hF;
        sched_valid = 1'b1;
        @(negedge clk);
        sched_valid = 1'b0;
        chk("acc_ready_low", sched_ready, 0);
        chk("acc_err", sched_err, 0);
        chk("acc_no_slot_start", slot_start, 0);
        wait_cnt(0);
        chk("promo_slot_start", slot_start, 1);
        chk("promo_ready", sched_ready, 1);

        for (int v = 0; v < 5; v++) begin
            in_en = vecs[v].in_en;
            xin   = vecs[v].din;
            @(negedge clk);
            chk($sformatf("vec%0d_en", v), out_en, vecs[v].exp_en);
            chk($sformatf("vec%0d_dat", v), xout, vecs[v].exp_dat);
        end

        // Identity schedule offered on the last slot cycle waits one full slot.
        wait_cnt(3);
        sched_sel   = 8'hE4;
        sched_en    = 4'hF;
        sched_valid = 1'b1;
        @(negedge clk);
        sched_valid = 1'b0;
        chk("resid_ready_low", sched_ready, 0);
        chk("resid_old_slot_start", slot_start, 1);
        for (int k = 0; k < 4; k++) begin
            in_en = 4'hF;
            d     = mkdat(32'h5000 + 32'(k * 16));
            xin   = d;
            @(negedge clk);
            chk($sformatf("resid_old_en%0d", k), out_en, 4'hF);
            chk($sformatf("resid_old_dat%0d", k), xout, rev(d));
        end
        chk("resid_ready_back", sched_ready, 1);
        d   = mkdat(32'h6000);
        xin = d;
        @(negedge clk);
        chk("resid_new_dat", xout, d);

        // Conflicting schedule: ingress1 and ingress3 lose.
        sched_sel   = 8'hA5;
        sched_en    = 4'hF;
        sched_valid = 1'b1;
        @(negedge clk);
        sched_valid = 1'b0;
        chk("conf_err_pulse", sched_err, 1);
        @(negedge clk);
        chk("conf_err_clear", sched_err, 0);
        wait_cnt(0);
        in_en = 4'hF;
        xin   = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        @(negedge clk);
        chk("conf_en", out_en, 4'b0110);
        chk("conf_dat", xout, {32'h0, 32'hE2, 32'hE0, 32'h0});
        in_en = 4'b0010;
        @(negedge clk);
        chk("conf_drop_en", out_en, 0);
        chk("conf_drop_dat", xout, 0);

        // Pending full with valid held: second schedule enters after promotion.
        wait_cnt(1);
        in_en       = 4'hF;
        sched_sel   = 8'hE4;
        sched_en    = 4'hF;
        sched_valid = 1'b1;
        @(negedge clk);
        sched_sel = 8'h1B;
        chk("hold_ready_low0", sched_ready, 0);
        @(negedge clk);
        chk("hold_ready_low1", sched_ready, 0);
        xin = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        @(negedge clk);
        chk("hold_ready_high", sched_ready, 1);
        chk("hold_boundary_en", out_en, 4'b0110);
        chk("hold_boundary_dat", xout, {32'h0, 32'hF2, 32'hF0, 32'h0});
        d   = mkdat(32'h7000);
        xin = d;
        @(negedge clk);
        sched_valid = 1'b0;
        chk("hold_second_acc", sched_ready, 0);
        chk("hold_err", sched_err, 0);
        chk("hold_identity", xout, d);
        wait_cnt(0);
        d   = mkdat(32'h8000);
        xin = d;
        @(negedge clk);
        chk("hold_second_rev", xout, rev(d));

        // Reset mid-slot while routing.
        wait_cnt(2);
        in_en = 4'hF;
        xin   = mkdat(32'h9000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_out_en", out_en, 0);
        chk("mrst_out", xout, 0);
        chk("mrst_ready", sched_ready, 1);
        chk("mrst_slot_start", slot_start, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("mrst_blocked_en", out_en, 0);
            chk("mrst_blocked_ss", slot_start, 0);
        end
        wait_cnt(1);
        sched_sel   = 8'hE4;
        sched_en    = 4'hF;
        sched_valid = 1'b1;
        @(negedge clk);
        sched_valid = 1'b0;
        wait_cnt(0);
        d   = mkdat(32'hA000);
        xin = d;
        @(negedge clk);
        chk("mrst_resume_en", out_en, 4'hF);
        chk("mrst_resume_dat", xout, d);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
